// File: rtl/spr_de_gamma_lut_ctrl.sv
// De-gamma LUT configuration controller: streams a full curve into the shadow bank,
// checks monotonicity and swaps banks only on a rising edge of i_vs.
module spr_de_gamma_lut_ctrl #(
    parameter int IN_W  = 11,
    parameter int OUT_W = 8,
    parameter int DEPTH = 2048
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_vs,
    input  logic             cfg_start,
    input  logic             cfg_abort,
    input  logic             cfg_valid,
    input  logic [OUT_W-1:0] cfg_data,
    output logic             cfg_ready,
    output logic             lut_we,
    output logic [IN_W-1:0]  lut_waddr,
    output logic [OUT_W-1:0] lut_wdata,
    output logic             lut_wbank,
    output logic             active_bank,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [IN_W-1:0] LAST_ADDR = IN_W'(DEPTH - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_PEND} state_t;

    state_t             state_q, state_d;
    logic [IN_W-1:0]    cnt_q, cnt_d;
    logic [OUT_W-1:0]   prev_q, prev_d;
    logic               mono_q, mono_d;
    logic               vs_q;
    logic               active_q, active_d;
    logic               ready_q, ready_d;
    logic               we_q, we_d;
    logic [IN_W-1:0]    waddr_q, waddr_d;
    logic [OUT_W-1:0]   wdata_q, wdata_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               vs_rise;
    logic               accept;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prev_d   = prev_q;
        mono_d   = mono_q;
        active_d = active_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        vs_rise  = i_vs & ~vs_q;
        accept   = cfg_valid & ready_q;

        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                    prev_d  = '0;
                    mono_d  = 1'b0;
                end
            end
            ST_LOAD: begin
                // Abort wins over a beat presented in the same cycle.
                if (cfg_abort) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else if (accept) begin
                    we_d    = 1'b1;
                    waddr_d = cnt_q;
                    wdata_d = cfg_data;
                    prev_d  = cfg_data;
                    if ((cnt_q != '0) && (cfg_data < prev_q)) begin
                        mono_d = 1'b1;
                    end
                    if (cnt_q == LAST_ADDR) begin
                        state_d = ST_PEND;
                    end else begin
                        cnt_d = cnt_q + IN_W'(1);
                    end
                end
            end
            ST_PEND: begin
                if (cfg_abort || mono_q) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else if (vs_rise) begin
                    state_d  = ST_IDLE;
                    active_d = ~active_q;
                    done_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_LOAD);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            prev_q   <= '0;
            mono_q   <= 1'b0;
            vs_q     <= 1'b0;
            active_q <= 1'b0;
            ready_q  <= 1'b0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prev_q   <= prev_d;
            mono_q   <= mono_d;
            vs_q     <= i_vs;
            active_q <= active_d;
            ready_q  <= ready_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign cfg_ready   = ready_q;
    assign lut_we      = we_q;
    assign lut_waddr   = waddr_q;
    assign lut_wdata   = wdata_q;
    assign active_bank = active_q;
    assign lut_wbank   = ~active_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_spr_de_gamma_lut_ctrl.sv
// Directed bench for spr_de_gamma_lut_ctrl: full loads, backpressure, non-monotonic
// curve, abort, vs coincident with last beat, and reset mid-operation.
module tb_spr_de_gamma_lut_ctrl;
    localparam int IN_W  = 11;
    localparam int OUT_W = 8;
    localparam int DEPTH = 2048;

    logic             clk = 1'b0;
    logic             rst, i_vs, cfg_start, cfg_abort, cfg_valid;
    logic [OUT_W-1:0] cfg_data;
    logic             cfg_ready, lut_we, lut_wbank, active_bank, busy, done, err;
    logic [IN_W-1:0]  lut_waddr;
    logic [OUT_W-1:0] lut_wdata;

    spr_de_gamma_lut_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .i_vs(i_vs), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready), .lut_we(lut_we),
        .lut_waddr(lut_waddr), .lut_wdata(lut_wdata), .lut_wbank(lut_wbank),
        .active_bank(active_bank), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Write monitor state, sampled on the falling edge.
    logic [OUT_W-1:0] exp_mem [DEPTH];
    logic exp_wbank = 1'b1;
    int wr_cnt = 0, gap_err = 0, bank_err = 0, data_err = 0;
    int done_cnt = 0, err_cnt = 0, last_addr = -1;

    always @(negedge clk) begin
        if (lut_we === 1'b1) begin
            if (lut_waddr != '0 && int'(lut_waddr) != last_addr + 1) gap_err++;
            if (lut_wbank !== exp_wbank) bank_err++;
            if (lut_wdata !== exp_mem[lut_waddr]) data_err++;
            last_addr = int'(lut_waddr);
            wr_cnt++;
        end
        if (done === 1'b1) done_cnt++;
        if (err === 1'b1) err_cnt++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_load;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    // Drives n accepted beats; pat 0 = valid always, pat 1 = valid 1,0,0,...
    task automatic do_load(input int n, input int pat, input int bad, input bit vs_last);
        int beat = 0;
        int k = 0;
        logic v, rdy;
        exp_wbank = ~active_bank;
        while (beat < n && k < 4 * DEPTH + 16) begin
            v = (pat == 0) || (k % 3 == 0);
            cfg_valid = v;
            cfg_data = (beat == bad) ? '0 : OUT_W'(beat >> 3);
            exp_mem[beat] = cfg_data;
            if (vs_last && v && beat == n - 1) i_vs = 1'b1;
            rdy = cfg_ready;
            tick();
            k++;
            if (rdy && v) beat++;
        end
        cfg_valid = 1'b0;
        n_chk++;
        if (beat != n) begin
            n_fail++;
            $display("FAIL load_timeout: got %0d beats expected %0d", beat, n);
        end
    endtask

    task automatic test_reset;
        int w0, e0;
        rst = 1'b1; i_vs = 1'b0; cfg_start = 1'b0; cfg_abort = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
        tick(); tick();
        n_chk++; if ({cfg_ready, lut_we, lut_waddr, lut_wdata, active_bank, busy, done, err} !== 25'd0) begin n_fail++; $display("FAIL reset_outputs: got %0h expected 0", {cfg_ready, lut_we, lut_waddr, lut_wdata, active_bank, busy, done, err}); end
        n_chk++; if (lut_wbank !== 1'b1) begin n_fail++; $display("FAIL reset_wbank: got %0b expected 1", lut_wbank); end
        rst = 1'b0;
        tick();
        w0 = wr_cnt; e0 = err_cnt;
        cfg_valid = 1'b1; cfg_data = 8'h55; cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        tick(); tick();
        cfg_valid = 1'b0;
        tick();
        n_chk++; if (wr_cnt != w0) begin n_fail++; $display("FAIL idle_valid_nowrite: got %0d writes expected 0", wr_cnt - w0); end
        n_chk++; if (err_cnt != e0 || busy !== 1'b0 || cfg_ready !== 1'b0) begin n_fail++; $display("FAIL idle_abort_noeffect: got err %0d busy %0b ready %0b expected 0 0 0", err_cnt - e0, busy, cfg_ready); end
    endtask

    task automatic test_full_load;
        int w0, g0, b0, d0, dn0, e0;
        w0 = wr_cnt; g0 = gap_err; b0 = bank_err; d0 = data_err; dn0 = done_cnt; e0 = err_cnt;
        start_load();
        n_chk++; if (cfg_ready !== 1'b1 || busy !== 1'b1 || lut_wbank !== 1'b1) begin n_fail++; $display("FAIL full_start: got ready %0b busy %0b wbank %0b expected 1 1 1", cfg_ready, busy, lut_wbank); end
        do_load(DEPTH, 0, -1, 1'b0);
        n_chk++; if (cfg_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL full_pend: got ready %0b busy %0b expected 0 1", cfg_ready, busy); end
        repeat (100) tick();
        n_chk++; if (active_bank !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL full_wait: got active %0b done %0b expected 0 0", active_bank, done); end
        i_vs = 1'b1;
        tick();
        n_chk++; if (done !== 1'b1 || active_bank !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL full_swap: got done %0b active %0b busy %0b expected 1 1 0", done, active_bank, busy); end
        tick();
        i_vs = 1'b0;
        n_chk++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL full_after: got done %0b busy %0b expected 0 0", done, busy); end
        n_chk++; if (wr_cnt - w0 != DEPTH || last_addr != DEPTH - 1) begin n_fail++; $display("FAIL full_writes: got %0d writes last %0d expected %0d last %0d", wr_cnt - w0, last_addr, DEPTH, DEPTH - 1); end
        n_chk++; if (gap_err != g0 || bank_err != b0 || data_err != d0) begin n_fail++; $display("FAIL full_wr_content: got gap %0d bank %0d data %0d errors expected 0", gap_err - g0, bank_err - b0, data_err - d0); end
        n_chk++; if (done_cnt - dn0 != 1 || err_cnt != e0) begin n_fail++; $display("FAIL full_pulses: got done %0d err %0d expected 1 0", done_cnt - dn0, err_cnt - e0); end
    endtask

    task automatic test_backpressure;
        int w0, g0, b0, d0;
        w0 = wr_cnt; g0 = gap_err; b0 = bank_err; d0 = data_err;
        start_load();
        n_chk++; if (lut_wbank !== 1'b0) begin n_fail++; $display("FAIL bp_wbank: got %0b expected 0", lut_wbank); end
        do_load(DEPTH, 1, -1, 1'b0);
        tick(); tick();
        n_chk++; if (wr_cnt - w0 != DEPTH || last_addr != DEPTH - 1) begin n_fail++; $display("FAIL bp_writes: got %0d writes last %0d expected %0d last %0d", wr_cnt - w0, last_addr, DEPTH, DEPTH - 1); end
        n_chk++; if (gap_err != g0 || bank_err != b0 || data_err != d0) begin n_fail++; $display("FAIL bp_wr_content: got gap %0d bank %0d data %0d errors expected 0", gap_err - g0, bank_err - b0, data_err - d0); end
        i_vs = 1'b1;
        tick();
        n_chk++; if (done !== 1'b1 || active_bank !== 1'b0) begin n_fail++; $display("FAIL bp_swap: got done %0b active %0b expected 1 0", done, active_bank); end
        i_vs = 1'b0;
        tick();
    endtask

    task automatic test_non_mono;
        int w0, d0, dn0, e0;
        w0 = wr_cnt; d0 = data_err; dn0 = done_cnt; e0 = err_cnt;
        start_load();
        do_load(DEPTH, 0, 500, 1'b0);
        n_chk++; if (err !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL nm_pend_entry: got err %0b busy %0b expected 0 1", err, busy); end
        tick();
        n_chk++; if (err !== 1'b1 || busy !== 1'b0 || active_bank !== 1'b0) begin n_fail++; $display("FAIL nm_err_pulse: got err %0b busy %0b active %0b expected 1 0 0", err, busy, active_bank); end
        tick();
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL nm_err_single: got %0b expected 0", err); end
        i_vs = 1'b1;
        tick(); tick();
        i_vs = 1'b0;
        tick();
        n_chk++; if (active_bank !== 1'b0 || done_cnt != dn0 || err_cnt - e0 != 1) begin n_fail++; $display("FAIL nm_no_swap: got active %0b done %0d err %0d expected 0 0 1", active_bank, done_cnt - dn0, err_cnt - e0); end
        n_chk++; if (wr_cnt - w0 != DEPTH || data_err != d0) begin n_fail++; $display("FAIL nm_writes: got %0d writes %0d data errors expected %0d 0", wr_cnt - w0, data_err - d0, DEPTH); end
    endtask

    task automatic test_abort;
        int w0, dn0, e0;
        w0 = wr_cnt; dn0 = done_cnt; e0 = err_cnt;
        start_load();
        do_load(1000, 0, -1, 1'b0);
        cfg_abort = 1'b1; cfg_valid = 1'b1; cfg_data = OUT_W'(1000 >> 3);
        tick();
        cfg_abort = 1'b0; cfg_valid = 1'b0;
        n_chk++; if (err !== 1'b1 || busy !== 1'b0 || cfg_ready !== 1'b0 || lut_we !== 1'b0) begin n_fail++; $display("FAIL abort_state: got err %0b busy %0b ready %0b we %0b expected 1 0 0 0", err, busy, cfg_ready, lut_we); end
        tick(); tick();
        n_chk++; if (wr_cnt - w0 != 1000 || last_addr != 999) begin n_fail++; $display("FAIL abort_writes: got %0d writes last %0d expected 1000 last 999", wr_cnt - w0, last_addr); end
        n_chk++; if (err_cnt - e0 != 1 || done_cnt != dn0 || active_bank !== 1'b0) begin n_fail++; $display("FAIL abort_pulses: got err %0d done %0d active %0b expected 1 0 0", err_cnt - e0, done_cnt - dn0, active_bank); end
        start_load();
        exp_mem[0] = 8'h00;
        cfg_valid = 1'b1; cfg_data = 8'h00;
        tick();
        cfg_valid = 1'b0;
        n_chk++; if (lut_we !== 1'b1 || lut_waddr !== '0) begin n_fail++; $display("FAIL abort_restart: got we %0b addr %0d expected 1 0", lut_we, lut_waddr); end
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        tick();
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_restart_idle: got busy %0b expected 0", busy); end
    endtask

    task automatic test_vs_coincident;
        int b0, dn0;
        b0 = bank_err; dn0 = done_cnt;
        start_load();
        n_chk++; if (lut_wbank !== 1'b1) begin n_fail++; $display("FAIL vsc_wbank1: got %0b expected 1", lut_wbank); end
        do_load(DEPTH, 0, -1, 1'b1);
        repeat (10) tick();
        n_chk++; if (active_bank !== 1'b0 || busy !== 1'b1 || done_cnt != dn0) begin n_fail++; $display("FAIL vsc_no_swap: got active %0b busy %0b done %0d expected 0 1 0", active_bank, busy, done_cnt - dn0); end
        i_vs = 1'b0;
        tick();
        i_vs = 1'b1;
        tick();
        n_chk++; if (done !== 1'b1 || active_bank !== 1'b1) begin n_fail++; $display("FAIL vsc_next_swap: got done %0b active %0b expected 1 1", done, active_bank); end
        i_vs = 1'b0;
        tick();
        start_load();
        n_chk++; if (lut_wbank !== 1'b0) begin n_fail++; $display("FAIL vsc_wbank0: got %0b expected 0", lut_wbank); end
        do_load(DEPTH, 0, -1, 1'b0);
        i_vs = 1'b1;
        tick();
        n_chk++; if (done !== 1'b1 || active_bank !== 1'b0) begin n_fail++; $display("FAIL vsc_second_swap: got done %0b active %0b expected 1 0", done, active_bank); end
        i_vs = 1'b0;
        tick();
        n_chk++; if (bank_err != b0) begin n_fail++; $display("FAIL vsc_wr_bank: got %0d bank errors expected 0", bank_err - b0); end
    endtask

    task automatic test_reset_mid;
        int dn0, e0;
        start_load();
        do_load(DEPTH, 0, -1, 1'b0);
        i_vs = 1'b1;
        tick();
        i_vs = 1'b0;
        tick();
        n_chk++; if (active_bank !== 1'b1) begin n_fail++; $display("FAIL rm_precond: got active %0b expected 1", active_bank); end
        dn0 = done_cnt; e0 = err_cnt;
        start_load();
        do_load(700, 0, -1, 1'b0);
        cfg_valid = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; cfg_valid = 1'b0;
        n_chk++; if ({cfg_ready, lut_we, lut_waddr, lut_wdata, active_bank, busy, done, err} !== 25'd0) begin n_fail++; $display("FAIL rm_load_reset: got %0h expected 0", {cfg_ready, lut_we, lut_waddr, lut_wdata, active_bank, busy, done, err}); end
        n_chk++; if (lut_wbank !== 1'b1) begin n_fail++; $display("FAIL rm_load_wbank: got %0b expected 1", lut_wbank); end
        tick(); tick();
        start_load();
        do_load(DEPTH, 0, -1, 1'b0);
        n_chk++; if (busy !== 1'b1 || cfg_ready !== 1'b0) begin n_fail++; $display("FAIL rm_pend_precond: got busy %0b ready %0b expected 1 0", busy, cfg_ready); end
        rst = 1'b1; i_vs = 1'b1;
        tick();
        rst = 1'b0;
        n_chk++; if ({cfg_ready, lut_we, lut_waddr, lut_wdata, active_bank, busy, done, err} !== 25'd0) begin n_fail++; $display("FAIL rm_pend_reset: got %0h expected 0", {cfg_ready, lut_we, lut_waddr, lut_wdata, active_bank, busy, done, err}); end
        tick();
        i_vs = 1'b0;
        tick(); tick();
        n_chk++; if (done_cnt != dn0 || err_cnt != e0 || active_bank !== 1'b0) begin n_fail++; $display("FAIL rm_no_pulses: got done %0d err %0d active %0b expected 0 0 0", done_cnt - dn0, err_cnt - e0, active_bank); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_full_load();
        test_backpressure();
        test_non_mono();
        test_abort();
        test_vs_coincident();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
